// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the loader state encoding and the fixed stream word width.
package program_loader_pkg;

    localparam int LOADER_DATA_W = 32;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/load_checksum.sv
// Wrapping 32-bit running sum of image words with synchronous clear.
// Ports: clk, reset (sync, active-low), clr, en, d in; sum out.
module load_checksum
    import program_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic [LOADER_DATA_W-1:0] d,
    output logic [LOADER_DATA_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: takes length, data words and checksum from a stream, writes
// imem and releases core_reset once the image checks out.
// Ports: clk, reset (sync, active-low), s_valid/s_data/s_ready stream,
//   restart, imem_we/imem_addr/imem_wdata, core_reset, load_done,
//   load_error, words_loaded.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t state, state_n;

    logic [ADDR_WIDTH:0]    len;
    logic [ADDR_WIDTH:0]    len_field;
    logic [ADDR_WIDTH:0]    wl_next;
    logic [DATA_WIDTH-1:0]  sum;
    logic beat, len_ok;
    logic clr, en, ld_len, rearm;

    assign s_ready   = (state == S_LEN) || (state == S_DATA) ||
                       (state == S_CSUM);
    assign beat      = s_valid && s_ready;
    assign len_field = s_data[ADDR_WIDTH:0];
    assign len_ok    = (len_field != '0) && (len_field <= CAP);
    assign wl_next   = words_loaded + ONE;

    load_checksum u_csum (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .d     (s_data),
        .sum   (sum)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LEN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        en      = 1'b0;
        ld_len  = 1'b0;
        rearm   = 1'b0;
        unique case (state)
            S_LEN: begin
                if (beat) begin
                    clr     = 1'b1;
                    ld_len  = 1'b1;
                    state_n = len_ok ? S_DATA : S_ERR;
                end
            end
            S_DATA: begin
                if (beat) begin
                    en = 1'b1;
                    if (wl_next == len) begin
                        state_n = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (beat) begin
                    state_n = (s_data == sum) ? S_RUN : S_ERR;
                end
            end
            S_RUN, S_ERR: begin
                if (restart) begin
                    rearm   = 1'b1;
                    state_n = S_LEN;
                end
            end
            default: state_n = S_LEN;
        endcase
    end

    // Status flags are derived from the next state so they move on the
    // same edge as the transition that causes them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_reset   <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
        end else begin
            imem_we    <= 1'b0;
            core_reset <= (state_n != S_RUN);
            load_done  <= (state_n == S_RUN);
            load_error <= (state_n == S_ERR);
            if (ld_len) begin
                len          <= len_field;
                words_loaded <= '0;
            end
            if (en) begin
                imem_we      <= 1'b1;
                imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                imem_wdata   <= s_data;
                words_loaded <= wl_next;
            end
            if (rearm) begin
                words_loaded <= '0;
            end
        end
    end

endmodule
